// File: rtl/mul_sequencer_if.sv
// Handshake and data bundle between the control unit and mul_sequencer.
// The master drives the request side and the slave (the sequencer)
// returns status and the registered product halves.
interface mul_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [5:0]       encoded_opcode;
    logic [WIDTH-1:0] rs1data;
    logic [WIDTH-1:0] rs2data;
    logic [7:0]       statusregin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] aluout1;
    logic [WIDTH-1:0] aluout2;
    logic [7:0]       statusregout;

    modport master (
        output start, encoded_opcode, rs1data, rs2data, statusregin,
        input  busy, done, aluout1, aluout2, statusregout
    );

    modport slave (
        input  start, encoded_opcode, rs1data, rs2data, statusregin,
        output busy, done, aluout1, aluout2, statusregout
    );
endinterface

// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle shift-add multiplier for MUL (unsigned) and
// MLS (signed, sign-magnitude with a final negate). The product is split
// over aluout1 (low half) and aluout2 (high half); status carries N/Z.
// Optional feature macro: MUL_EARLY_TERM_EN -- leave RUN as soon as the
// remaining multiplier bits are all zero instead of always taking WIDTH
// cycles. Results are identical either way; only latency differs.
module mul_sequencer #(
    parameter int         WIDTH  = 16,
    parameter logic [5:0] OP_MUL = 6'b100001,
    parameter logic [5:0] OP_MLS = 6'b100010
) (
    input logic           clk,
    input logic           reset,
    mul_sequencer_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Magnitude of a two's complement operand; the most negative value maps
    // onto itself, which is the correct magnitude when read as unsigned.
    function automatic logic [WIDTH-1:0] fn_abs(input logic signed [WIDTH-1:0] v);
        return (v < 0) ? -v : v;
    endfunction

    // Two's complement negate of the full-width accumulator.
    function automatic logic [2*WIDTH-1:0] fn_negate(input logic [2*WIDTH-1:0] v);
        return ~v + 1'b1;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   aluout1_q, aluout1_d;
    logic [WIDTH-1:0]   aluout2_q, aluout2_d;
    logic [7:0]         status_q, status_d;

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d;

    logic               accept_w;
    logic               last_w;
    logic [2*WIDTH-1:0] result_w;
    logic               unused_status_lsbs;

    // The low two status bits are replaced by N and Z, so they are never read.
    assign unused_status_lsbs = ^bus.statusregin[1:0];

    assign accept_w = (state_q == S_IDLE) && bus.start &&
                      ((bus.encoded_opcode == OP_MUL) || (bus.encoded_opcode == OP_MLS));

    // Next-state and datapath update for the IDLE -> RUN -> FIX sequence.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aluout1_d = aluout1_q;
        aluout2_d = aluout2_q;
        status_d  = status_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        last_w    = 1'b0;
        result_w  = neg_q ? fn_negate(acc_q) : acc_q;

        case (state_q)
            S_IDLE: begin
                if (accept_w) begin
                    if (bus.encoded_opcode == OP_MLS) begin
                        mcand_d  = {{WIDTH{1'b0}}, fn_abs(bus.rs1data)};
                        mplier_d = fn_abs(bus.rs2data);
                        neg_d    = bus.rs1data[WIDTH-1] ^ bus.rs2data[WIDTH-1];
                    end else begin
                        mcand_d  = {{WIDTH{1'b0}}, bus.rs1data};
                        mplier_d = bus.rs2data;
                        neg_d    = 1'b0;
                    end
                    acc_d   = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
`ifdef MUL_EARLY_TERM_EN
                last_w   = (count_q == CNT_W'(WIDTH - 1)) || ((mplier_q >> 1) == '0);
`else
                last_w   = (count_q == CNT_W'(WIDTH - 1));
`endif
                if (last_w) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                aluout1_d = result_w[WIDTH-1:0];
                aluout2_d = result_w[2*WIDTH-1:WIDTH];
                status_d  = {bus.statusregin[7:2], result_w[2*WIDTH-1], (result_w == '0)};
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state and visible outputs; cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aluout1_q <= '0;
            aluout2_q <= '0;
            status_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aluout1_q <= aluout1_d;
            aluout2_q <= aluout2_d;
            status_q  <= status_d;
        end
    end

    // Shift-add working registers; always reloaded on accept, so no reset.
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        acc_q    <= acc_d;
        neg_q    <= neg_d;
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.aluout1      = aluout1_q;
    assign bus.aluout2      = aluout2_q;
    assign bus.statusregout = status_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Testbench for mul_sequencer: table of hand-computed products plus
// hand-written sequences for reset, ignored starts and back-to-back issue.
module tb_mul_sequencer;

    localparam logic [5:0] OP_MUL = 6'b100001;
    localparam logic [5:0] OP_MLS = 6'b100010;

    logic clk;
    logic reset;

    mul_sequencer_if #(.WIDTH(16)) bus ();

    mul_sequencer #(.WIDTH(16), .OP_MUL(OP_MUL), .OP_MLS(OP_MLS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  sr;
        logic [15:0] a1;
        logic [15:0] a2;
        logic        n;
        logic        z;
    } vec_t;

    typedef struct {
        logic [15:0] a1;
        logic [15:0] a2;
        logic [7:0]  st;
        int          lat;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Start-to-done edge count: WIDTH+1 normally, run+1 with early exit.
    function automatic int exp_latency(input logic [5:0] op, input logic [15:0] b);
        logic [15:0] m;
        int run;
        m = (op == OP_MLS && b[15]) ? (~b + 16'd1) : b;
        run = 1;
        for (int i = 0; i < 16; i++) if (m[i]) run = i + 1;
`ifndef MUL_EARLY_TERM_EN
        run = 16;
`endif
        return run + 1;
    endfunction

    function automatic exp_t model(input logic [5:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic [7:0] sr);
        logic signed [31:0] sa, sb2;
        logic [31:0] p;
        exp_t e;
        sa  = $signed(a);
        sb2 = $signed(b);
        if (op == OP_MLS) p = sa * sb2;
        else              p = {16'd0, a} * {16'd0, b};
        e.a1  = p[15:0];
        e.a2  = p[31:16];
        e.st  = {sr[7:2], p[31], (p == 32'd0)};
        e.lat = exp_latency(op, b);
        return e;
    endfunction

    // Present a request for one edge, starting from a point just after an edge.
    task automatic issue(input logic [5:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [7:0] sr);
        bus.start          = 1'b1;
        bus.encoded_opcode = op;
        bus.rs1data        = a;
        bus.rs2data        = b;
        bus.statusregin    = sr;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    endtask

    // Wait (bounded) for done, then compare against the scoreboard head.
    task automatic collect(input string tag);
        int   lat;
        bit   seen;
        exp_t e;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.done) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done in %0d edges, want done", tag, lat);
        end else if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_unexpected_done: got done, want no result pending", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_lo"},      {16'd0, bus.aluout1},     {16'd0, e.a1});
            check({tag, "_hi"},      {16'd0, bus.aluout2},     {16'd0, e.a2});
            check({tag, "_status"},  {24'd0, bus.statusregout}, {24'd0, e.st});
            check({tag, "_latency"}, lat,                       e.lat);
            check({tag, "_busy_lo"}, {31'd0, bus.busy},         32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int   dones;
        exp_t e;
        logic [15:0] ra, rb;
        logic [5:0]  rop;

        tbl[0] = '{OP_MUL, 16'hFFFF, 16'hFFFF, 8'hA5, 16'h0001, 16'hFFFE, 1'b1, 1'b0};
        tbl[1] = '{OP_MLS, 16'h8000, 16'h8000, 8'h5A, 16'h0000, 16'h4000, 1'b0, 1'b0};
        tbl[2] = '{OP_MLS, 16'hFFFF, 16'h0005, 8'hFF, 16'hFFFB, 16'hFFFF, 1'b1, 1'b0};
        tbl[3] = '{OP_MUL, 16'h1234, 16'h0000, 8'hA5, 16'h0000, 16'h0000, 1'b0, 1'b1};
        tbl[4] = '{OP_MUL, 16'h0003, 16'h0004, 8'h00, 16'h000C, 16'h0000, 1'b0, 1'b0};
        tbl[5] = '{OP_MLS, 16'h0003, 16'hFFFE, 8'h3C, 16'hFFFA, 16'hFFFF, 1'b1, 1'b0};
        tbl[6] = '{OP_MLS, 16'h7FFF, 16'h7FFF, 8'hC3, 16'h0001, 16'h3FFF, 1'b0, 1'b0};
        tbl[7] = '{OP_MLS, 16'h0000, 16'hFFFF, 8'h81, 16'h0000, 16'h0000, 1'b0, 1'b1};
        tbl[8] = '{OP_MUL, 16'h8000, 16'h0002, 8'h10, 16'h0000, 16'h0001, 1'b0, 1'b0};
        tbl[9] = '{OP_MLS, 16'h8000, 16'h0001, 8'hFC, 16'h8000, 16'hFFFF, 1'b1, 1'b0};

        // Reset state
        reset              = 1'b1;
        bus.start          = 1'b0;
        bus.encoded_opcode = 6'd0;
        bus.rs1data        = 16'd0;
        bus.rs2data        = 16'd0;
        bus.statusregin    = 8'd0;
        #1;
        check("reset_busy",   {31'd0, bus.busy},         32'd0);
        check("reset_done",   {31'd0, bus.done},         32'd0);
        check("reset_lo",     {16'd0, bus.aluout1},      32'd0);
        check("reset_hi",     {16'd0, bus.aluout2},      32'd0);
        check("reset_status", {24'd0, bus.statusregout}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Table vectors, each issued in the done cycle of the previous one
        for (int i = 0; i < 10; i++) begin
            e.a1  = tbl[i].a1;
            e.a2  = tbl[i].a2;
            e.st  = {tbl[i].sr[7:2], tbl[i].n, tbl[i].z};
            e.lat = exp_latency(tbl[i].op, tbl[i].b);
            sb.push_back(e);
            issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sr);
            collect($sformatf("vec%0d", i));
        end

        // A few pseudo-random operands against the arithmetic model
        for (int i = 0; i < 4; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rop = (i % 2 == 0) ? OP_MLS : OP_MUL;
            sb.push_back(model(rop, ra, rb, 8'h6B));
            issue(rop, ra, rb, 8'h6B);
            collect($sformatf("rnd%0d", i));
        end

        // Reset during RUN discards the operation and clears all outputs
        @(posedge clk);
        #1;
        issue(OP_MUL, 16'hFFFF, 16'hFFFF, 8'hFF);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_busy",   {31'd0, bus.busy},         32'd0);
        check("midreset_done",   {31'd0, bus.done},         32'd0);
        check("midreset_lo",     {16'd0, bus.aluout1},      32'd0);
        check("midreset_hi",     {16'd0, bus.aluout2},      32'd0);
        check("midreset_status", {24'd0, bus.statusregout}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.push_back(model(OP_MUL, 16'h0003, 16'h0004, 8'h00));
        issue(OP_MUL, 16'h0003, 16'h0004, 8'h00);
        collect("after_reset");

        // Starts while busy are ignored: one done pulse, first operands only
        @(posedge clk);
        #1;
        sb.push_back(model(OP_MUL, 16'h00FF, 16'hFFFF, 8'h24));
        issue(OP_MUL, 16'h00FF, 16'hFFFF, 8'h24);
        dones = 0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 3 || c == 10) begin
                bus.start          = 1'b1;
                bus.encoded_opcode = OP_MUL;
                bus.rs1data        = 16'h0005;
                bus.rs2data        = 16'h0007;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("busy_start_lo",      {16'd0, bus.aluout1}, {16'd0, e.a1});
                    check("busy_start_hi",      {16'd0, bus.aluout2}, {16'd0, e.a2});
                    check("busy_start_latency", c,                    e.lat);
                end
            end
        end
        check("busy_start_done_count", dones, 1);
        check("busy_start_idle_after", {31'd0, bus.busy}, 32'd0);

        // Unsupported opcode: nothing starts
        bus.start          = 1'b1;
        bus.encoded_opcode = 6'b010001;
        bus.rs1data        = 16'h0002;
        bus.rs2data        = 16'h0002;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("badop_busy", {31'd0, bus.busy}, 32'd0);
        dones = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) dones++;
        end
        check("badop_no_activity", dones, 0);

        // Back-to-back: second request presented in the first one's done cycle
        sb.push_back(model(OP_MLS, 16'hFFF0, 16'h0010, 8'h99));
        issue(OP_MLS, 16'hFFF0, 16'h0010, 8'h99);
        collect("b2b_first");
        sb.push_back(model(OP_MUL, 16'hABCD, 16'h1357, 8'h42));
        issue(OP_MUL, 16'hABCD, 16'h1357, 8'h42);
        collect("b2b_second");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
